// File: rtl/col_crop.sv
// Column crop: drops LEFT_PAD leading and RIGHT_PAD trailing beats of every row.
// Define COL_CROP_LEN_CHECK_EN to build the sticky short-row / width-mismatch flag.
module col_crop #(
    parameter int TUSER_WIDTH = 5,
    parameter int TDEST_WIDTH = 2,
    parameter int TDATA_WIDTH = 8,
    parameter int LEFT_PAD    = 2,
    parameter int RIGHT_PAD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   err_short_row
);

    localparam int D  = RIGHT_PAD + 1;
    localparam int OW = $clog2(D + 1);
    localparam int EW = TDATA_WIDTH + TUSER_WIDTH + TDEST_WIDTH;
    localparam logic [OW-1:0] OCC_FULL = OW'(D);
    localparam logic [3:0]    HEAD_END = 4'(LEFT_PAD);

    typedef enum logic [1:0] {
        S_HEAD,
        S_BODY,
        S_TAIL
    } state_t;

    // With no leading pad the head phase has nothing to drop.
    localparam state_t S_START = (LEFT_PAD == 0) ? S_BODY : S_HEAD;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             head_cnt;
    logic [3:0]             head_nxt;
    logic [OW-1:0]          occ;
    logic [OW-1:0]          occ_nxt;
    logic [OW-1:0]          wr_idx;
    logic [TUSER_WIDTH-1:0] acc;
    logic [TUSER_WIDTH-1:0] acc_nxt;
    logic [EW-1:0]          mem     [D];
    logic [EW-1:0]          mem_nxt [D];
    logic [EW-1:0]          in_entry;

    logic full;
    logic accept;
    logic emit;
    logic push;
    logic pop;
    logic tail_short;
    logic row_done;
    logic flush;

    assign full = (occ == OCC_FULL);

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (state)
            S_HEAD: begin
                s_axis_tready = !rst;
            end
            S_BODY: begin
                s_axis_tready = !rst && (!full || m_axis_tready);
                m_axis_tvalid = full;
            end
            S_TAIL: begin
                m_axis_tvalid = full;
                m_axis_tlast  = full;
            end
            default: ;
        endcase
    end

    assign accept     = s_axis_tvalid && s_axis_tready;
    assign emit       = m_axis_tvalid && m_axis_tready;
    assign push       = accept && (state == S_BODY);
    assign pop        = emit && (state == S_BODY);
    assign tail_short = (state == S_TAIL) && !full;
    assign row_done   = emit && (state == S_TAIL);
    assign flush      = row_done || tail_short;

    // Any start-of-frame seen on a dropped head beat rides on the first kept beat.
    assign in_entry = {s_axis_tdata, s_axis_tuser | acc, s_axis_tdest};
    assign wr_idx   = pop ? occ - 1'b1 : occ;

    always_comb begin
        state_nxt = state;
        head_nxt  = head_cnt;
        acc_nxt   = acc;
        unique case (state)
            S_HEAD: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        head_nxt = '0;
                        acc_nxt  = '0;
                    end else begin
                        head_nxt = head_cnt + 4'd1;
                        acc_nxt  = acc | s_axis_tuser;
                        if (head_cnt + 4'd1 == HEAD_END) begin
                            state_nxt = S_BODY;
                        end
                    end
                end
            end
            S_BODY: begin
                if (push) begin
                    acc_nxt = '0;
                    if (s_axis_tlast) begin
                        state_nxt = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (flush) begin
                    state_nxt = S_START;
                    head_nxt  = '0;
                end
            end
            default: state_nxt = S_START;
        endcase
    end

    always_comb begin
        occ_nxt = occ;
        if (flush) begin
            occ_nxt = '0;
        end else if (push && !pop) begin
            occ_nxt = occ + 1'b1;
        end else if (pop && !push) begin
            occ_nxt = occ - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < D; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop) begin
            for (int i = 0; i < D - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < D; i++) begin
                if (OW'(i) == wr_idx) begin
                    mem_nxt[i] = in_entry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_START;
            head_cnt <= '0;
            occ      <= '0;
            acc      <= '0;
            for (int i = 0; i < D; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            head_cnt <= head_nxt;
            occ      <= occ_nxt;
            acc      <= acc_nxt;
            for (int i = 0; i < D; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

    assign m_axis_tdata = mem[0][EW-1 -: TDATA_WIDTH];
    assign m_axis_tuser = mem[0][TDEST_WIDTH +: TUSER_WIDTH];
    assign m_axis_tdest = mem[0][TDEST_WIDTH-1:0];

`ifdef COL_CROP_LEN_CHECK_EN
    logic [15:0] body_cnt;
    logic [15:0] ref_cnt;
    logic        ref_vld;
    logic        err_q;
    logic        short_row;

    assign short_row = (accept && (state == S_HEAD) && s_axis_tlast) || tail_short;

    // Pushed-beat count per row; kept width differs from it by the constant RIGHT_PAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            body_cnt <= '0;
            ref_cnt  <= '0;
            ref_vld  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push && body_cnt != 16'hFFFF) begin
                body_cnt <= body_cnt + 16'd1;
            end
            if (row_done || short_row) begin
                body_cnt <= '0;
            end
            if (row_done) begin
                if (!ref_vld) begin
                    ref_cnt <= body_cnt;
                    ref_vld <= 1'b1;
                end else if (ref_cnt != body_cnt) begin
                    err_q <= 1'b1;
                end
            end
            if (short_row) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_short_row = err_q;
`else
    assign err_short_row = 1'b0;
`endif

endmodule
